// File: rtl/pipe_pkg.sv
// Shared LSU types: access size, bridge FSM states and byte-lane helpers.
package pipe_pkg;

  typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2, SZ_D = 2'd3} lsu_size_e;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_REQ = 2'd1, ST_WAIT = 2'd2, ST_RESP = 2'd3} lsu_state_e;

  // Byte enables for an access of `size` starting at lane `off` (8-lane form).
  function automatic logic [7:0] lsu_lane_mask(input lsu_size_e size, input logic [2:0] off);
    logic [7:0] m;
    case (size)
      SZ_B:    m = 8'h01;
      SZ_H:    m = 8'h03;
      SZ_W:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m << off;
  endfunction

  function automatic logic lsu_misaligned(input lsu_size_e size, input logic [2:0] a);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return a[0];
      SZ_W:    return |a[1:0];
      default: return |a[2:0];
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store data/strobe placement and load extract + extension.
module lsu_align
  import pipe_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int NB   = XLEN / 8,
  parameter int OW   = $clog2(NB)
) (
  input  logic [1:0]      size,
  input  logic [OW-1:0]   off,
  input  logic            uns,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] wdata_sh,
  output logic [NB-1:0]   wstrb,
  output logic [XLEN-1:0] ld_data
);

  logic [XLEN-1:0] rsh;

  assign wdata_sh = wdata << {off, 3'b000};
  assign wstrb    = NB'(lsu_lane_mask(lsu_size_e'(size), 3'(off)));
  assign rsh      = rdata >> {off, 3'b000};

  // Width casts of signed slices sign-extend, avoiding zero-width replications at XLEN=32.
  always_comb begin
    ld_data = rsh;
    case (lsu_size_e'(size))
      SZ_B: ld_data = uns ? XLEN'(rsh[7:0])  : XLEN'($signed(rsh[7:0]));
      SZ_H: ld_data = uns ? XLEN'(rsh[15:0]) : XLEN'($signed(rsh[15:0]));
      SZ_W: ld_data = uns ? XLEN'(rsh[31:0]) : XLEN'($signed(rsh[31:0]));
      default: ld_data = rsh;
    endcase
  end

endmodule

// File: rtl/lsu_mem_bridge.sv
// Load/store unit bridging the memory stage to a valid/ready bus port,
// with alignment trapping, response timeout, flush handling and stall.
module lsu_mem_bridge
  import pipe_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter int TIMEOUT   = 255,
  parameter int ALIGN_CHK = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [4:0]        req_rd,
  input  logic              flush,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic [4:0]        rsp_rd,
  output logic              rsp_err,
  output logic              stall,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [XLEN-1:0]   mem_addr,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_wstrb,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_rsp_err
);

  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  localparam int CW = $clog2(TIMEOUT + 2);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  lsu_state_e      state;
  logic [OW-1:0]   off_q;
  logic [1:0]      size_q;
  logic            uns_q, we_q, drop;
  logic [CW-1:0]   cnt;
  logic [OW-1:0]   a_off;
  logic [1:0]      a_size;
  logic [XLEN-1:0] a_wdata, a_ld;
  logic [NB-1:0]   a_strb;
  logic            req_err, accept;

  // The aligner sees the live request in IDLE and the latched one afterwards.
  assign a_off  = (state == ST_IDLE) ? req_addr[OW-1:0] : off_q;
  assign a_size = (state == ST_IDLE) ? req_size : size_q;

  lsu_align #(.XLEN(XLEN)) u_align (
    .size(a_size), .off(a_off), .uns(uns_q), .wdata(req_wdata), .rdata(mem_rdata),
    .wdata_sh(a_wdata), .wstrb(a_strb), .ld_data(a_ld)
  );

  assign req_err = (XLEN == 32 && req_size == 2'd3) ||
                   (ALIGN_CHK != 0 && lsu_misaligned(lsu_size_e'(req_size), req_addr[2:0]));

  assign req_ready     = (state == ST_IDLE) && !flush;
  assign accept        = req_ready && req_valid;
  assign stall         = (state != ST_IDLE);
  assign mem_req_valid = (state == ST_REQ);
  assign rsp_valid     = (state == ST_RESP) && !drop && !flush;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      off_q     <= '0;
      size_q    <= '0;
      uns_q     <= 1'b0;
      we_q      <= 1'b0;
      drop      <= 1'b0;
      cnt       <= '0;
      rsp_rdata <= '0;
      rsp_rd    <= '0;
      rsp_err   <= 1'b0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else begin
      case (state)
        ST_IDLE: if (accept) begin
          off_q  <= req_addr[OW-1:0];
          size_q <= req_size;
          uns_q  <= req_unsigned;
          we_q   <= req_we;
          rsp_rd <= req_rd;
          drop   <= 1'b0;
          if (req_err) begin
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            state     <= ST_RESP;
          end else begin
            mem_addr  <= {req_addr[XLEN-1:OW], OW'(0)};
            mem_we    <= req_we;
            mem_wdata <= a_wdata;
            mem_wstrb <= a_strb;
            state     <= ST_REQ;
          end
        end
        ST_REQ: if (mem_req_ready) begin
          cnt   <= '0;
          drop  <= flush;
          state <= ST_WAIT;
        end else if (flush) begin
          state <= ST_IDLE;
        end
        ST_WAIT: begin
          if (flush) drop <= 1'b1;
          cnt <= cnt + 1'b1;
          if (mem_rsp_valid) begin
            rsp_err   <= mem_rsp_err;
            rsp_rdata <= (we_q || mem_rsp_err) ? '0 : a_ld;
            state     <= ST_RESP;
          end else if (TIMEOUT != 0 && cnt == TO_LAST) begin
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            state     <= ST_RESP;
          end
        end
        default: begin
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
          drop      <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
